// File: rtl/psum_ofifo_if.sv
// psum_ofifo_if: row-write / row-pop bundle between MAC row, output FIFO and SFU.
// master drives in/wr/rd; slave returns o_valid/o_full/out/o_out_vld.
interface psum_ofifo_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [col*psum_bw-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic                   o_valid;
  logic                   o_full;
  logic [col*psum_bw-1:0] out;
  logic                   o_out_vld;

  modport master (
    output in, wr, rd,
    input  o_valid, o_full, out, o_out_vld
  );

  modport slave (
    input  in, wr, rd,
    output o_valid, o_full, out, o_out_vld
  );
endinterface

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-lane psum FIFOs, skewed writes, row-wide registered pops.
// Ports: clk, reset (async active-low), bus (slave); option macro PSUM_OFIFO_RELU_EN.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic        clk,
  input  logic        reset,
  psum_ofifo_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [PW-1:0]      wptr_q [col];
  logic [PW-1:0]      wptr_d [col];
  logic [PW-1:0]      rptr_q;
  logic [PW-1:0]      rptr_d;
  logic [psum_bw-1:0] mem_q  [col][depth];

  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col-1:0]         wen;
  logic                   pop;
  logic [col*psum_bw-1:0] out_q;
  logic [col*psum_bw-1:0] out_d;
  logic                   vld_q;
  logic                   vld_d;

  function automatic logic [psum_bw-1:0] lane_fn(
    input logic [psum_bw-1:0] v
  );
`ifdef PSUM_OFIFO_RELU_EN
    return v[psum_bw-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Flags come straight from the pointers; the read
  // pointer is shared so rows stay aligned.
  always_comb begin
    empty = '0;
    full  = '0;
    wen   = '0;
    for (int j = 0; j < col; j++) begin
      empty[j] = (wptr_q[j] == rptr_q);
      full[j]  = (wptr_q[j][AW-1:0] == rptr_q[AW-1:0])
              && (wptr_q[j][AW] != rptr_q[AW]);
      wen[j]   = bus.wr[j] && !full[j];
    end
  end

  assign bus.o_valid   = &(~empty);
  assign bus.o_full    = |full;
  assign pop           = bus.rd && bus.o_valid;
  assign bus.out       = out_q;
  assign bus.o_out_vld = vld_q;

  always_comb begin
    rptr_d = rptr_q + PW'(pop);
    out_d  = out_q;
    vld_d  = pop;
    for (int j = 0; j < col; j++) begin
      wptr_d[j] = wptr_q[j] + PW'(wen[j]);
      if (pop) begin
        out_d[j*psum_bw +: psum_bw] =
          lane_fn(mem_q[j][rptr_q[AW-1:0]]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr_q <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      for (int j = 0; j < col; j++) begin
        wptr_q[j] <= '0;
      end
    end else begin
      rptr_q <= rptr_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      for (int j = 0; j < col; j++) begin
        wptr_q[j] <= wptr_d[j];
      end
    end
  end

  // Storage is not reset; stale entries are never
  // visible because the pointers are.
  always_ff @(posedge clk) begin
    for (int j = 0; j < col; j++) begin
      if (wen[j]) begin
        mem_q[j][wptr_q[j][AW-1:0]] <=
          bus.in[j*psum_bw +: psum_bw];
      end
    end
  end
endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Per-column output FIFO directly downstream of the MAC row array. It captures each column's partial sum (`out_s` slice) when that column's valid bit pulses. Valid bits arrive skewed across columns, one cycle per column, so each column is buffered independently. A whole row of `col` psums is released to the SFU/accumulation stage only once every column holds at least one entry.

## Interface
Parameters:
- `col`, 8: number of columns/psum lanes; equals MAC row width.
- `psum_bw`, 16: psum width per lane, two's complement.
- `depth`, 64: entries per column FIFO; power of two, ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state immediately on assertion.
- `in`, input, `col*psum_bw`: lane j = `in[(j+1)*psum_bw-1 : j*psum_bw]`, driven by MAC row `out_s`.
- `wr`, input, `col`: per-lane write strobe, driven by MAC row `valid`.
- `rd`, input, 1: pop one full row.
- `o_valid`, output, 1: every lane non-empty, so a row is available.
- `o_full`, output, 1: at least one lane holds `depth` entries.
- `out`, output, `col*psum_bw`: registered popped row, same lane packing as `in`.
- `o_out_vld`, output, 1: one-cycle pulse marking that `out` was updated by a pop.

## Operation
- Storage: `col` independent circular buffers, each `depth` × `psum_bw`.
- Each lane has its own write pointer. The lanes share one read pointer, because pops are always row-wide.
- Pointers are log2(`depth`)+1 bits wide; the MSB is the wrap bit.
- Lane j is empty when its write pointer equals the read pointer.
- Lane j is full when the low bits of its write pointer and the read pointer are equal and the MSBs differ.
- Write: when `wr[j]` is high and lane j is not full, lane j stores its slice of `in` at the write pointer and the write pointer increments, wrapping mod 2·`depth`.
- Write to a full lane: the data is dropped and the pointer is unchanged. No other lane is affected.
- `o_valid` = AND over all lanes of (not empty).
- `o_full` = OR over all lanes of (full).
- Pop: when `rd` is high and `o_valid` is high:
  - `out` ← head entry of every lane;
  - the read pointer increments;
  - `o_out_vld` = 1 in the next cycle.
- `rd` while `o_valid` is low: ignored. `out` holds its value and `o_out_vld` = 0.
- Simultaneous write and pop on the same lane: both take effect, so that lane's occupancy is unchanged.
  - A write to a full lane during a pop is still dropped; fullness is evaluated before the pop.
  - A pop on an empty lane never happens, because `o_valid` gates it.
- Occupancy differs per lane, by up to `col`-1 entries in normal skewed operation. Rows stay aligned because the read pointer is shared.

## Timing
- Reset values: all pointers 0; `out` = 0; `o_out_vld` = 0; `o_valid` = 0; `o_full` = 0. Memory contents are not reset.
- Write latency: `wr[j]` sampled at edge N updates the pointer at N. `o_valid` and `o_full` are combinational from the pointers and reflect the write from cycle N+1.
- Read latency: `rd` accepted at edge N drives `out` and `o_out_vld` = 1 during cycle N+1.
- Back-to-back pops, one per cycle, are supported while `o_valid` stays high.
- Throughput: one row in and one row out per cycle at steady state.
- Reset asserted mid-operation: all state clears asynchronously, and partial rows are discarded. The first write after reset release lands at index 0.

## Configuration
- `PSUM_OFIFO_RELU_EN` defined: each lane of a popped row passes through ReLU before it is registered into `out`. A negative value (MSB = 1) becomes 0; any other value passes unchanged.
- `PSUM_OFIFO_RELU_EN` undefined: `out` is the raw head entry.
- Storage contents and flags are identical in both builds.

## Test plan
- Reset, then `wr` = 8'h01 for one cycle, lane 0 `in` = 16'h0005 -> lane 0 non-empty, `o_valid` stays 0, `o_full` = 0.
- Skewed fill: `wr[j]` pulses at cycle j for j = 0..7, lane j data = j+1 -> `o_valid` rises the cycle after the lane 7 write. `rd` -> next cycle `out` = {8,7,...,1} (lane 7 MSB) and `o_out_vld` = 1. `o_valid` then falls.
- Fill all lanes to 64 entries -> `o_full` = 1. Extra `wr` = 8'hFF with data 16'hDEAD is dropped. Popping 64 rows returns the original sequence and never returns DEAD.
- Steady stream with `wr` = 8'hFF and `rd` = 1 every cycle, continuing past 2·`depth` entries -> pointers wrap, output is in order, no gaps.
- Simultaneous `wr` and `rd` with the lanes at 63 entries, then `rd` while `o_valid` = 0 -> occupancy stays 63. The ignored `rd` leaves `out` unchanged and `o_out_vld` = 0.
- `PSUM_OFIFO_RELU_EN` with lane 3 value 16'hFFF0 -> popped lane 3 = 0. Without the macro -> 16'hFFF0. Reset pulsed mid-stream -> `o_valid` = 0 and `out` = 0 immediately.
